// File: rtl/uart_tx_arbiter_if.sv
// Purpose: byte-producer / serializer bundle for uart_tx_arbiter.
//   req_valid  producer -> arbiter, one bit per requester
//   req_data   producer -> arbiter, byte i at [8*i+7:8*i]
//   req_ready  arbiter -> producer, one-hot accept pulse
//   tx_data    arbiter -> uartTx data, stable for the frame
//   tx_start   arbiter -> uartTx start, one pulse per frame
//   grant_id   index of the current/last granted requester
//   busy       frame (and optional gap) in progress
// Modports: master (producer side), slave (arbiter side).
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic [GW-1:0]        grant_id;
    logic                 busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_data, tx_start, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_data, tx_start, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one uartTx serializer between NUM_REQ byte
// producers. Accepts one byte per valid/ready handshake, pulses tx_start,
// then self-times the frame with a cycle counter (uartTx has no busy flag).
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous reset, active-low
//   bus   uart_tx_arbiter_if.slave (req_valid/req_data/req_ready,
//         tx_data/tx_start/grant_id/busy)
// Optional feature: define UART_ARB_GAP_EN to add one bit-time of line idle
// (GAP state) after every frame.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FRAME_BITS   = 10
) (
    input logic             clk,
    input logic             rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
    localparam int unsigned CW         = $clog2(FRAME_CLKS + 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CLKS - 1);
    localparam logic [GW-1:0] LAST_ID    = GW'(NUM_REQ - 1);
`ifdef UART_ARB_GAP_EN
    localparam logic [CW-1:0] GAP_LAST   = CW'(CLKS_PER_BIT - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
`ifdef UART_ARB_GAP_EN
        ,
        GAP   = 2'd3
`endif
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       cnt;
    logic [GW-1:0]       rr_ptr;
    logic [GW-1:0]       sel;
    logic                found;
    logic                accept;
    logic                frame_done;
    logic [NUM_REQ-1:0]  ready;
    logic [7:0]          tx_data_q;
    logic [GW-1:0]       grant_q;
    logic                tx_start_q;
    logic                busy_q;

    assign frame_done = (state == WAIT) && (cnt == FRAME_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (found) state_next = START;
            START: state_next = WAIT;
            WAIT: begin
`ifdef UART_ARB_GAP_EN
                if (frame_done) state_next = GAP;
`else
                if (frame_done) state_next = IDLE;
`endif
            end
`ifdef UART_ARB_GAP_EN
            GAP:   if (cnt == GAP_LAST) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Output logic: round-robin pick starting at rr_ptr, one-hot accept pulse
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[(32'(rr_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                sel   = GW'((32'(rr_ptr) + k) % NUM_REQ);
            end
        end
        accept = (state == IDLE) && found;
        ready  = accept ? (NUM_REQ'(1) << sel) : '0;
    end

    // Datapath and registered outputs; tx_start/busy follow the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            rr_ptr     <= '0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_start_q <= (state_next == START);
            busy_q     <= (state_next != IDLE);
            if (accept) begin
                tx_data_q <= bus.req_data[32'(sel) * 8 +: 8];
                grant_q   <= sel;
            end
            if (frame_done) rr_ptr <= (grant_q == LAST_ID) ? '0 : grant_q + GW'(1);
            case (state)
                START: cnt <= '0;
                WAIT:  cnt <= frame_done ? '0 : cnt + CW'(1);
`ifdef UART_ARB_GAP_EN
                GAP:   cnt <= cnt + CW'(1);
`endif
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.tx_data   = tx_data_q;
    assign bus.grant_id  = grant_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: NUM_REQ=4, CLKS_PER_BIT=4, FRAME_BITS=10, 20 ns clk.
// Producers are per-requester byte queues; each load also pushes the
// hand-derived grant (id, byte) into the scoreboard, which a negedge monitor
// pops on every tx_start. Define UART_ARB_GAP_EN for the gap build.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
`ifdef UART_ARB_GAP_EN
    localparam int unsigned OCC = 45;
`else
    localparam int unsigned OCC = 41;
`endif

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (NREQ),
        .CLKS_PER_BIT(4),
        .FRAME_BITS  (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [7:0] src_q [NREQ][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic load(input int id, input logic [7:0] b);
        src_q[id].push_back(b);
    endtask

    task automatic expect_grant(input int id, input logic [7:0] b);
        exp_t e;
        e.id   = 2'(id);
        e.data = b;
        sb.push_back(e);
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    // Producer model: drop the accepted byte after the edge, present the next one
    initial begin
        logic [NREQ-1:0] acc;
        bus.req_valid = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && rst && src_q[i].size() != 0) void'(src_q[i].pop_front());
                bus.req_valid[i] = (src_q[i].size() != 0);
                bus.req_data[8*i +: 8] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
            end
        end
    end

    // Monitor / scoreboard
    int unsigned cyc = 0;
    int unsigned last_start = 0;
    int unsigned blen = 0;
    bit have_start = 1'b0;
    bit prev_busy  = 1'b0;
    bit exp_start  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            blen = 0; prev_busy = 1'b0; exp_start = 1'b0; have_start = 1'b0;
        end else begin
            if (exp_start) begin
                check("start_latency", 32'(bus.tx_start), 32'd1);
                exp_start = 1'b0;
            end
            if (bus.tx_start) begin
                check("frame_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("grant_id", 32'(bus.grant_id), 32'(e.id));
                    check("tx_data", 32'(bus.tx_data), 32'(e.data));
                end
                last_start = cyc;
                have_start = 1'b1;
            end
            if (bus.req_ready != '0) begin
                check("ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                check("ready_when_idle", 32'(bus.busy), 32'd0);
                if (prev_busy && have_start)
                    check("occupancy", cyc - last_start, OCC);
                exp_start = 1'b1;
            end
            if (bus.busy) blen++;
            else if (prev_busy) begin
                check("busy_len", blen, OCC);
                blen = 0;
            end
            prev_busy = bus.busy;
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while ((sb.size() != 0 || bus.busy || pending()) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 3000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_start"},  32'(bus.tx_start),  32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
        check({tag, "_grant_id"},  32'(bus.grant_id),  32'd0);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    endtask

    initial begin
        int n;
        // 1: reset
        rst = 1'b0;
        #100;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end

        // 2: single request
        load(2, 8'hA5); expect_grant(2, 8'hA5);
        wait_done("single_done");

        // 3: contention from pointer 0
        do_reset();
        load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);
        expect_grant(0, 8'h11); expect_grant(1, 8'h22);
        expect_grant(2, 8'h33); expect_grant(3, 8'h44);
        wait_done("contention_done");

        // 4: after grant to 3 the pointer wraps to 0
        load(0, 8'hC0); load(3, 8'hC3);
        expect_grant(0, 8'hC0); expect_grant(3, 8'hC3);
        wait_done("wrap_done");
        load(1, 8'hD1); load(1, 8'hD2); load(1, 8'hD3);
        expect_grant(1, 8'hD1); expect_grant(1, 8'hD2); expect_grant(1, 8'hD3);
        wait_done("repeat_done");
        // pointer now 2: search 2,3,0 -> 0, then 1
        load(0, 8'hE0); load(1, 8'hE1);
        expect_grant(0, 8'hE0); expect_grant(1, 8'hE1);
        wait_done("wrap2_done");

        // 5: reset mid-frame; frame abandoned, pointer back to 0
        load(2, 8'h5A); expect_grant(2, 8'h5A);
        n = 0;
        while (!bus.tx_start && n < 200) begin @(negedge clk); n++; end
        check("mid_start_seen", 32'(n < 200), 32'd1);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_zero("midreset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        load(1, 8'h77); load(3, 8'h99);
        expect_grant(1, 8'h77); expect_grant(3, 8'h99);
        wait_done("post_reset_done");
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
